uart_stim_tx: RTL and testbench
===============================

Name: uart_stim_tx

Overview:
Parametrised UART transmitter with an input byte FIFO. It is the next-generation serial stimulus/response path for the pipeline debug interface. It drives the pipeline's rx line from benches and serves as the debug unit's tx source in synthesis. Data width, parity mode, stop-bit count, bit period and FIFO depth are all parametrised, so one block covers every frame format the debug protocol uses.

Parameters:
DATA_BITS, 8, payload bits per frame; legal values are 5 to 9.
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; legal values are 1 or 2.
CLKS_PER_BIT, 16, clock cycles per serial bit; must be 2 or more.
ADDR_BITS, 2, FIFO address width; FIFO depth is 2**ADDR_BITS.

Ports:
clk  in  1  system clock; everything is sampled on its rising edge.
reset  in  1  asynchronous, active-high reset.
wr_en  in  1  push wr_data into the FIFO.
wr_data  in  DATA_BITS  byte to transmit.
full  out  1  FIFO holds 2**ADDR_BITS entries.
empty  out  1  FIFO holds 0 entries.
overflow  out  1  one-cycle pulse when a write is dropped.
busy  out  1  high whenever the FSM is not in IDLE.
tx  out  1  serial line; idle level is 1.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - tx=1, busy=0, overflow=0, full=0, empty=1.
  - FIFO pointers and count cleared; FSM goes to IDLE; bit counter and cycle counter cleared.
  - Reset asserted mid-frame aborts the frame: tx returns to 1 at once and no partial frame resumes after reset is released.
- FIFO:
  - Circular buffer with 2**ADDR_BITS entries; an explicit count of width ADDR_BITS+1 separates full from empty.
  - Read and write pointers wrap modulo the depth.
  - Write while not full: the entry is stored.
  - Write while full with no pop in the same cycle: data is discarded, overflow=1 for one cycle, FIFO contents unchanged.
  - Write while full with a pop in the same cycle: the write is accepted, count is unchanged, no overflow.
  - Push and pop in the same cycle while empty cannot happen, because pop requires empty=0 at the sampling edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. When empty=0, pop the head entry into the shift register, load the cycle counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] (LSB first), held CLKS_PER_BIT cycles per bit. After bit DATA_BITS-1, go to PARITY if PARITY!=0, otherwise go to STOP.
  - PARITY: tx = XOR of the payload bits (even mode) or its inverse (odd mode), held CLKS_PER_BIT cycles. Parity is computed from the popped byte, not the shifted register.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. In the last cycle: if empty=0, pop and go straight to START (back-to-back frames, zero idle gap); otherwise go to IDLE.
- Timing:
  - Frame length is (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
  - Latency from a wr_en sampled at edge N into an idle, empty block: empty=0 after edge N, pop at edge N+1, tx=0 after edge N+1.
- busy=1 from the pop edge until the FSM re-enters IDLE.
- tx is a registered output with no combinational path from any input.
- wr_data above DATA_BITS does not exist; the port width is exactly DATA_BITS.

Test Plan:
1. DATA_BITS=8, PARITY=0, STOP_BITS=1, CLKS_PER_BIT=4. Write 0x55 once -> tx reads 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles, 40 cycles total. busy=1 for exactly 40 cycles. empty=1 one cycle after the write.
2. PARITY=1 writing 0x07 -> parity bit=1; PARITY=2 writing 0x07 -> parity bit=0. Frame is 44 cycles at CLKS_PER_BIT=4.
3. ADDR_BITS=2. Five consecutive writes 0xA1..0xA5 with the FSM idle -> first byte popped at the second edge. Writes 2-5 fill the FIFO (full=1 after the 5th write), no overflow. A sixth write while full with no pop -> overflow=1 for one cycle and 0xA6 is never transmitted. Five frames go out back-to-back (200 cycles at 8N1, CLKS_PER_BIT=4) with no idle cycle between stop and start.
4. FIFO full, with the FSM popping in the same cycle as a write of 0xB0 -> no overflow, full stays 1, and 0xB0 is transmitted last.
5. Assert reset 13 cycles into an 8N1 frame -> tx=1 immediately, busy=0, empty=1. After release, tx stays 1 with no residual frame for at least 100 cycles.
6. DATA_BITS=7, STOP_BITS=2, PARITY=0, CLKS_PER_BIT=4. Write 0x7F -> start bit, seven 1s, stop held 8 cycles, 40 cycles total. The next queued frame starts only after the second stop bit.

Source files
------------

// File: rtl/uart_stim_tx.sv
// uart_stim_tx: parametrised UART transmitter fed by a circular byte FIFO
module uart_stim_tx #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_BITS    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 busy,
  output logic                 tx
);
  localparam int CNT_MAX = STOP_BITS * CLKS_PER_BIT - 1;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] BIT_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LOAD = CW'(CNT_MAX);
  localparam logic [ADDR_BITS:0] FULL_CNT = {1'b1, {ADDR_BITS{1'b0}}};
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0] count_q, count_d;
  logic overflow_q, overflow_d, tx_q, tx_d, par_q, par_d;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, head;
  logic pop, push, last;
  assign full = count_q == FULL_CNT;
  assign empty = count_q == '0;
  assign overflow = overflow_q;
  assign busy = state_q != S_IDLE;
  assign tx = tx_q;
  assign head = mem[rd_ptr_q];
  assign last = cnt_q == '0;
  // FIFO bookkeeping: a full FIFO still accepts a write when a pop frees a slot that cycle
  always_comb begin
    push = wr_en && (!full || pop);
    overflow_d = wr_en && full && !pop;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + (ADDR_BITS + 1)'(push) - (ADDR_BITS + 1)'(pop);
  end
  // Frame sequencer; parity is taken from the popped byte and held for the whole frame
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    par_d = par_q;
    pop = 1'b0;
    cnt_d = (state_q == S_IDLE || last) ? cnt_q : cnt_q - 1'b1;
    case (state_q)
      S_IDLE: pop = !empty;
      S_START: if (last) begin
        state_d = S_DATA;
        bit_d = '0;
        cnt_d = BIT_LOAD;
      end
      S_DATA: if (last) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + 4'd1;
        cnt_d = BIT_LOAD;
        if (bit_q == 4'(DATA_BITS - 1)) begin
          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          cnt_d = (PARITY != 0) ? BIT_LOAD : STOP_LOAD;
        end
      end
      S_PARITY: if (last) begin
        state_d = S_STOP;
        cnt_d = STOP_LOAD;
      end
      S_STOP: if (last) begin
        pop = !empty;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      state_d = S_START;
      shift_d = head;
      par_d = (^head) ^ (PARITY == 2);
      cnt_d = BIT_LOAD;
    end
    tx_d = state_d == S_START ? 1'b0 : state_d == S_DATA ? shift_d[0] : state_d == S_PARITY ? par_d : 1'b1;
  end
  // FIFO storage needs no reset; only the pointers and count define its contents
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end
  // State registers; reset aborts any frame in flight and forces the line idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
      state_q <= S_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_q <= par_d;
      tx_q <= tx_d;
    end
  end
endmodule

// File: tb/tb_uart_stim_tx.sv
// tb_uart_stim_tx: four frame formats (8N1, 8E1, 8O1, 7N2) checked cycle by cycle against a frame-level model
module tb_uart_stim_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] wr_en_v = '0;
  logic [7:0] wd [4];
  logic [3:0] full_v, empty_v, ovf_v, busy_v, tx_v;
  int checks = 0;
  int passed = 0;
  bit sv[$];
  int sd[$];
  always #5 clk = ~clk;
  uart_stim_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(4), .ADDR_BITS(2)) u0 (
    .clk(clk), .reset(reset), .wr_en(wr_en_v[0]), .wr_data(wd[0]), .full(full_v[0]),
    .empty(empty_v[0]), .overflow(ovf_v[0]), .busy(busy_v[0]), .tx(tx_v[0]));
  uart_stim_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(4), .ADDR_BITS(2)) u1 (
    .clk(clk), .reset(reset), .wr_en(wr_en_v[1]), .wr_data(wd[1]), .full(full_v[1]),
    .empty(empty_v[1]), .overflow(ovf_v[1]), .busy(busy_v[1]), .tx(tx_v[1]));
  uart_stim_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(4), .ADDR_BITS(2)) u2 (
    .clk(clk), .reset(reset), .wr_en(wr_en_v[2]), .wr_data(wd[2]), .full(full_v[2]),
    .empty(empty_v[2]), .overflow(ovf_v[2]), .busy(busy_v[2]), .tx(tx_v[2]));
  uart_stim_tx #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(4), .ADDR_BITS(2)) u3 (
    .clk(clk), .reset(reset), .wr_en(wr_en_v[3]), .wr_data(wd[3][6:0]), .full(full_v[3]),
    .empty(empty_v[3]), .overflow(ovf_v[3]), .busy(busy_v[3]), .tx(tx_v[3]));

  function automatic int db(int k); return k == 3 ? 7 : 8; endfunction
  function automatic int pm(int k); return k == 1 ? 1 : k == 2 ? 2 : 0; endfunction
  function automatic int sb(int k); return k == 3 ? 2 : 1; endfunction
  function automatic int frame_cycles(int k);
    return (1 + db(k) + (pm(k) != 0 ? 1 : 0) + sb(k)) * 4;
  endfunction
  // Serial bit i of the frame carrying byte b: start, LSB-first data, optional parity, stop bits
  function automatic logic frame_bit(int k, int b, int i);
    int ones;
    ones = $countones(b & ((1 << db(k)) - 1));
    if (i == 0) return 1'b0;
    if (i <= db(k)) return b[i-1];
    if (pm(k) != 0 && i == db(k) + 1) return pm(k) == 1 ? ones[0] : ~ones[0];
    return 1'b1;
  endfunction

  // Replays the write schedule in sv/sd on instance k; the model pops whenever the line is free
  task automatic run(input int k, input string name);
    int mq[$];
    int cur, s, free_at, n, f;
    bit w, pop, acc;
    logic etx, ebusy, eovf, efull, eempty;
    cur = 0; s = 0; free_at = 0;
    f = frame_cycles(k);
    n = sv.size() + 5 * f + 8;
    for (int t = 0; t < n; t++) begin
      w = t < sv.size() ? sv[t] : 1'b0;
      wr_en_v[k] = w;
      wd[k] = t < sd.size() ? 8'(sd[t]) : 8'h00;
      @(posedge clk);
      pop = mq.size() > 0 && t >= free_at;
      acc = w && (mq.size() < 4 || pop);
      if (pop) begin
        cur = mq.pop_front();
        s = t;
        free_at = t + f;
      end
      if (acc) mq.push_back(sd[t]);
      @(negedge clk);
      wr_en_v[k] = 1'b0;
      etx = t < free_at ? frame_bit(k, cur, (t - s) / 4) : 1'b1;
      ebusy = t < free_at;
      eovf = w && !acc;
      efull = mq.size() == 4;
      eempty = mq.size() == 0;
      checks++;
      if (tx_v[k] !== etx) $display("FAIL %s tx k=%0d t=%0d got %b exp %b", name, k, t, tx_v[k], etx); else passed++;
      checks++;
      if (busy_v[k] !== ebusy) $display("FAIL %s busy k=%0d t=%0d got %b exp %b", name, k, t, busy_v[k], ebusy); else passed++;
      checks++;
      if (ovf_v[k] !== eovf) $display("FAIL %s overflow k=%0d t=%0d got %b exp %b", name, k, t, ovf_v[k], eovf); else passed++;
      checks++;
      if (full_v[k] !== efull) $display("FAIL %s full k=%0d t=%0d got %b exp %b", name, k, t, full_v[k], efull); else passed++;
      checks++;
      if (empty_v[k] !== eempty) $display("FAIL %s empty k=%0d t=%0d got %b exp %b", name, k, t, empty_v[k], eempty); else passed++;
    end
    sv.delete();
    sd.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({tx_v[k], busy_v[k], ovf_v[k], full_v[k], empty_v[k]} !== 5'b10001)
        $display("FAIL reset k=%0d got tx,busy,ovf,full,empty=%b exp 10001", k,
                 {tx_v[k], busy_v[k], ovf_v[k], full_v[k], empty_v[k]});
      else passed++;
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    sv = '{1}; sd = '{8'h55}; run(0, "frame_55");
    sv = '{1}; sd = '{int'($urandom_range(0, 255))}; run(0, "frame_rand");
  endtask

  task automatic test_parity();
    sv = '{1}; sd = '{8'h07}; run(1, "even_07");
    sv = '{1}; sd = '{8'h07}; run(2, "odd_07");
    sv = '{1, 0, 1}; sd = '{int'($urandom_range(0, 255)), 0, int'($urandom_range(0, 255))}; run(1, "even_rand");
    sv = '{1, 1}; sd = '{int'($urandom_range(0, 255)), int'($urandom_range(0, 255))}; run(2, "odd_rand");
  endtask

  task automatic test_overflow();
    sv = '{1, 1, 1, 1, 1, 1};
    sd = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    run(0, "overflow");
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 42; i++) begin
      sv.push_back(i < 5 || i == 41);
      sd.push_back(i < 5 ? 8'hB1 + i : 8'hB0);
    end
    run(0, "full_pop");
  endtask

  task automatic test_two_stop();
    sv = '{1, 1}; sd = '{8'h7F, 8'h2A};
    run(3, "two_stop");
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 150; i++) begin
        sv.push_back($urandom_range(0, 3) == 0);
        sd.push_back(int'($urandom_range(0, 255)) & ((1 << db(k)) - 1));
      end
      run(k, "random");
    end
  endtask

  task automatic test_reset_mid_frame();
    wr_en_v[0] = 1'b1;
    wd[0] = 8'hC3;
    @(negedge clk);
    wr_en_v[0] = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    checks++;
    if (busy_v[0] !== 1'b1) $display("FAIL midframe_busy got %b exp 1", busy_v[0]); else passed++;
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({tx_v[0], busy_v[0], empty_v[0]} !== 3'b101)
      $display("FAIL midframe_reset got tx,busy,empty=%b exp 101", {tx_v[0], busy_v[0], empty_v[0]});
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if ({tx_v[0], busy_v[0]} !== 2'b10)
        $display("FAIL post_reset_idle cycle=%0d got tx,busy=%b exp 10", i, {tx_v[0], busy_v[0]});
      else passed++;
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) wd[k] = 8'h00;
    test_reset();
    test_single_frame();
    test_parity();
    test_overflow();
    test_full_pop();
    test_two_stop();
    test_random();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
